bsg_nasti_req_arbiter: RTL and testbench

//  Shares the single tunnel request channel (bsg_tun_dmx_t, valid/yumi) among
//  NUM_REQ NASTI client request streams. Grants round-robin at transaction

---
 rtl/bsg_nasti_pkg.sv | 16 +
 rtl/bsg_rr_pick.sv | 29 ++
 rtl/bsg_nasti_req_arbiter.sv | 121 ++++++++++++
 tb/tb_bsg_nasti_req_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_nasti_pkg.sv
// Shared NASTI tunnel types: the tunnel request beat and the request arbiter state.
package bsg_nasti_pkg;

    // One beat on the tunnel request channel (AR, AW or W payload plus routing tag).
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } bsg_tun_dmx_t;

    // Request arbiter FSM: free to arbitrate, or held by one requester mid-transaction.
    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bsg_rr_pick.sv
// Circular priority pick: first set bit of valid_i at or after ptr_i, wrapping.
// When nothing is valid, idx_o falls back to ptr_i.
module bsg_rr_pick #(
    parameter  int num_req_p     = 4,
    localparam int lg_num_req_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]     valid_i,
    input  logic [lg_num_req_lp-1:0] ptr_i,
    output logic [lg_num_req_lp-1:0] idx_o,
    output logic                     found_o
);

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        int j;
        j       = 0;
        idx_o   = ptr_i;
        found_o = 1'b0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= num_req_p) j = j - num_req_p;
            if (valid_i[j[lg_num_req_lp-1:0]]) begin
                idx_o   = j[lg_num_req_lp-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_nasti_req_arbiter.sv
// Round-robin arbiter sharing the tunnel request channel among NASTI clients.
// A grant is held for a whole transaction (AW + all W beats) so beats of one
// write never interleave with another requester on the tunnel.
module bsg_nasti_req_arbiter
    import bsg_nasti_pkg::*;
#(
    parameter  int num_req_p     = 4,
    parameter  int timeout_p     = 256,
    localparam int lg_num_req_lp = $clog2(num_req_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [num_req_p-1:0]     req_valid_i,
    input  bsg_tun_dmx_t             req_data_i [num_req_p],
    input  logic [num_req_p-1:0]     req_last_i,
    output logic [num_req_p-1:0]     req_yumi_o,
    output logic                     req_valid_o,
    output bsg_tun_dmx_t             req_data_o,
    input  logic                     req_yumi_i,
    output logic [lg_num_req_lp-1:0] req_src_o,
    output logic                     lock_timeout_o
);

    localparam int                     cnt_w_lp    = $clog2(timeout_p + 1);
    localparam logic [cnt_w_lp-1:0]    timeout_lp  = cnt_w_lp'(timeout_p);
    localparam logic [lg_num_req_lp-1:0] last_idx_lp = lg_num_req_lp'(num_req_p - 1);

    arb_state_e                state_q, state_d;
    logic [lg_num_req_lp-1:0]  rr_ptr_q, rr_ptr_d;
    logic [lg_num_req_lp-1:0]  lock_idx_q, lock_idx_d;
    logic [cnt_w_lp-1:0]       idle_q, idle_d;
    logic                      timeout_q, timeout_d;

    logic [lg_num_req_lp-1:0]  pick_idx;
    logic                      pick_found;

    // Next requester index with wrap; handles non-power-of-2 requester counts.
    function automatic logic [lg_num_req_lp-1:0] inc_wrap(input logic [lg_num_req_lp-1:0] v);
        if (v == last_idx_lp) return '0;
        return v + 1'b1;
    endfunction

    bsg_rr_pick #(
        .num_req_p (num_req_p)
    ) u_pick (
        .valid_i   (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .idx_o     (pick_idx),
        .found_o   (pick_found)
    );

    // State, pointers, idle counter and sticky timeout flag; reset drops any lock.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ARB_UNLOCKED;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            idle_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
        end
    end

    // Grant selection, lock transitions and idle tracking.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        idle_d      = '0;
        timeout_d   = timeout_q;
        req_src_o   = pick_idx;
        req_valid_o = pick_found;

        case (state_q)
            ARB_UNLOCKED: begin
                // The tunnel only yumis a valid beat, so pick_idx is the winner here.
                if (req_yumi_i) begin
                    if (req_last_i[pick_idx]) begin
                        rr_ptr_d = inc_wrap(pick_idx);
                    end else begin
                        state_d    = ARB_LOCKED;
                        lock_idx_d = pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                req_src_o   = lock_idx_q;
                req_valid_o = req_valid_i[lock_idx_q];
                if (!req_valid_i[lock_idx_q]) begin
                    idle_d = (idle_q == timeout_lp) ? idle_q : idle_q + 1'b1;
                end
                if (req_yumi_i && req_last_i[lock_idx_q]) begin
                    state_d  = ARB_UNLOCKED;
                    rr_ptr_d = inc_wrap(lock_idx_q);
                end
            end
            default: begin
                state_d = ARB_UNLOCKED;
            end
        endcase

        // Diagnostic only: the lock is kept even after the flag fires.
        if (idle_d == timeout_lp) timeout_d = 1'b1;
    end

    // Unregistered data mux and consume routing back to the selected requester.
    always_comb begin
        req_data_o = req_data_i[req_src_o];
        for (int i = 0; i < num_req_p; i++) begin
            req_yumi_o[i] = req_yumi_i & (req_src_o == lg_num_req_lp'(i));
        end
    end

    assign lock_timeout_o = timeout_q;

endmodule

// File: tb/tb_bsg_nasti_req_arbiter.sv
// Scoreboard bench for bsg_nasti_req_arbiter: four requesters, short timeout.
module tb_bsg_nasti_req_arbiter;
    import bsg_nasti_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_valid_i;
    bsg_tun_dmx_t req_data_i [4];
    logic [3:0]   req_last_i;
    logic [3:0]   req_yumi_o;
    logic         req_valid_o;
    bsg_tun_dmx_t req_data_o;
    logic         req_yumi_i;
    logic [1:0]   req_src_o;
    logic         lock_timeout_o;

    typedef struct { bsg_tun_dmx_t d; logic last; } beat_t;
    typedef struct { logic [1:0] src; bsg_tun_dmx_t d; } exp_t;

    beat_t rq [4][$];
    exp_t  sb [$];
    logic [3:0] hold;
    logic       tun_en;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    bsg_nasti_req_arbiter #(
        .num_req_p      (4),
        .timeout_p      (8)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_last_i     (req_last_i),
        .req_yumi_o     (req_yumi_o),
        .req_valid_o    (req_valid_o),
        .req_data_o     (req_data_o),
        .req_yumi_i     (req_yumi_i),
        .req_src_o      (req_src_o),
        .lock_timeout_o (lock_timeout_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bsg_tun_dmx_t mk(input int i, input logic [7:0] tag);
        bsg_tun_dmx_t d;
        d.tag  = tag;
        d.data = 32'hA500_0000 + 32'(i * 65536) + 32'(tag);
        return d;
    endfunction

    task automatic push(input int i, input logic [7:0] tag, input logic last);
        beat_t b;
        b.d    = mk(i, tag);
        b.last = last;
        rq[i].push_back(b);
    endtask

    task automatic expect_beat(input int s, input logic [7:0] tag);
        exp_t e;
        e.src = 2'(s);
        e.d   = mk(s, tag);
        sb.push_back(e);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            req_data_i[i] = '0;
        end
        sb.delete();
        req_valid_i = '0;
        req_last_i  = '0;
        req_yumi_i  = 1'b0;
        hold        = '0;
        tun_en      = 1'b1;
    endtask

    // Drive one cycle's inputs (called at negedge), respond as the tunnel, score handshakes.
    task automatic cyc();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0 && !hold[i]) begin
                req_valid_i[i] = 1'b1;
                req_data_i[i]  = rq[i][0].d;
                req_last_i[i]  = rq[i][0].last;
            end else begin
                req_valid_i[i] = 1'b0;
                req_data_i[i]  = '0;
                req_last_i[i]  = 1'b0;
            end
        end
        #1;
        req_yumi_i = tun_en & req_valid_o;
        #1;
        if (req_yumi_i) begin
            check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("src", 64'(req_src_o), 64'(e.src));
                check_eq("data", 64'(req_data_o), 64'(e.d));
                check_eq("yumi_onehot", 64'(req_yumi_o), 64'(4'b0001 << e.src));
            end
            if (rq[req_src_o].size() > 0) void'(rq[req_src_o].pop_front());
        end else begin
            check_eq("yumi_quiet", 64'(req_yumi_o), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            cyc();
            tick();
            n++;
        end
        check_eq({name, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_stim();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid_o", 64'(req_valid_o), 64'd0);
        check_eq("rst_src", 64'(req_src_o), 64'd0);
        check_eq("rst_flag", 64'(lock_timeout_o), 64'd0);
        check_eq("rst_yumi_o", 64'(req_yumi_o), 64'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Fairness: every requester always has a single-beat read pending.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                push(i, 8'(8'h10 + r * 4 + i), 1'b1);
                expect_beat(i, 8'(8'h10 + r * 4 + i));
            end
        end
        run_until_empty("fair", 40);

        // Burst lock: req0 AW + 3 W, req1 waiting with two reads.
        push(0, 8'h20, 1'b0); push(0, 8'h21, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h23, 1'b1);
        push(1, 8'h24, 1'b1); push(1, 8'h25, 1'b1);
        expect_beat(0, 8'h20); expect_beat(0, 8'h21); expect_beat(0, 8'h22); expect_beat(0, 8'h23);
        expect_beat(1, 8'h24); expect_beat(1, 8'h25);
        run_until_empty("burst", 20);

        // Idle: no valid, source follows the round-robin pointer (now 2).
        cyc();
        check_eq("idle_valid", 64'(req_valid_o), 64'd0);
        check_eq("idle_src", 64'(req_src_o), 64'd2);
        tick();

        // Gap in lock: req2 stalls for 10 cycles while req3 waits.
        push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b0); push(2, 8'h32, 1'b1);
        push(3, 8'h33, 1'b1);
        expect_beat(2, 8'h30); expect_beat(2, 8'h31); expect_beat(2, 8'h32); expect_beat(3, 8'h33);
        cyc();
        tick();
        hold[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check_eq("gap_valid_o", 64'(req_valid_o), 64'd0);
            check_eq("gap_src", 64'(req_src_o), 64'd2);
            tick();
        end
        hold[2] = 1'b0;
        run_until_empty("gap", 20);
        check_eq("gap_flag", 64'(lock_timeout_o), 64'd1);

        // Timeout: flag rises after exactly 8 idle locked cycles and stays set.
        do_reset();
        push(1, 8'h40, 1'b0); push(1, 8'h41, 1'b1);
        push(2, 8'h42, 1'b1);
        expect_beat(1, 8'h40); expect_beat(1, 8'h41); expect_beat(2, 8'h42);
        cyc();
        tick();
        hold[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check_eq("to_pre", 64'(lock_timeout_o), 64'd0);
            tick();
        end
        cyc();
        check_eq("to_set", 64'(lock_timeout_o), 64'd1);
        tick();
        hold[1] = 1'b0;
        run_until_empty("to", 20);
        check_eq("to_sticky", 64'(lock_timeout_o), 64'd1);

        // Backpressure: tunnel stalls 5 cycles in the middle of req3's burst.
        push(3, 8'h50, 1'b0); push(3, 8'h51, 1'b0); push(3, 8'h52, 1'b0); push(3, 8'h53, 1'b1);
        push(0, 8'h54, 1'b1);
        expect_beat(3, 8'h50); expect_beat(3, 8'h51); expect_beat(3, 8'h52); expect_beat(3, 8'h53);
        expect_beat(0, 8'h54);
        cyc();
        tick();
        tun_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_eq("bp_valid", 64'(req_valid_o), 64'd1);
            check_eq("bp_src", 64'(req_src_o), 64'd3);
            check_eq("bp_data", 64'(req_data_o), 64'(mk(3, 8'h51)));
            tick();
        end
        tun_en = 1'b1;
        run_until_empty("bp", 20);

        // Async reset in the middle of req1's burst, between clock edges.
        push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
        push(3, 8'h63, 1'b1);
        expect_beat(1, 8'h60); expect_beat(1, 8'h61);
        cyc();
        tick();
        cyc();
        #1;
        reset_n = 1'b0;
        clear_stim();
        #1;
        check_eq("arst_valid_o", 64'(req_valid_o), 64'd0);
        check_eq("arst_src", 64'(req_src_o), 64'd0);
        check_eq("arst_flag", 64'(lock_timeout_o), 64'd0);
        check_eq("arst_yumi_o", 64'(req_yumi_o), 64'd0);
        do_reset();
        push(2, 8'h64, 1'b1);
        push(0, 8'h65, 1'b1);
        expect_beat(0, 8'h65); expect_beat(2, 8'h64);
        run_until_empty("post_rst", 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
